// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// States, owner encoding and access-size codes used by the arbiter and its helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2,
        ERR_RSP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and memory port signals around the arbiter.
// slave: arbiter view; master: requester/memory environment view.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    if_req_i;
    logic [ADDR_WIDTH-1:0]   if_addr_i;
    logic                    if_gnt_o;
    logic                    if_rvalid_o;
    logic [DATA_WIDTH-1:0]   if_rdata_o;

    logic                    d_req_i;
    logic                    d_we_i;
    logic [1:0]              d_size_i;
    logic [ADDR_WIDTH-1:0]   d_addr_i;
    logic [DATA_WIDTH-1:0]   d_wdata_i;
    logic                    d_gnt_o;
    logic                    d_rvalid_o;
    logic                    d_err_o;
    logic [DATA_WIDTH-1:0]   d_rdata_o;

    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [DATA_WIDTH/8-1:0] mem_be_o;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic                    mem_gnt_i;
    logic                    mem_rvalid_i;
    logic [DATA_WIDTH-1:0]   mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_err_o, d_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_err_o, d_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_be_gen.sv
// Byte-enable, write-lane replication and misalignment detect for a data access.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_be_gen
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]              size_i,
    input  logic [1:0]              addr_lo_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH/8-1:0] be_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic                    misalign_o
);
    localparam int BE_W = DATA_WIDTH / 8;

    always_comb begin
        be_o       = '1;
        wdata_o    = wdata_i;
        misalign_o = 1'b0;
        case (size_i)
            MEM_SIZE_B: begin
                be_o    = BE_W'(1) << addr_lo_i;
                wdata_o = {BE_W{wdata_i[7:0]}};
            end
            MEM_SIZE_H: begin
                be_o       = BE_W'(3) << {addr_lo_i[1], 1'b0};
                wdata_o    = {(BE_W/2){wdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            // size 2'b11 is treated as a word access
            default: begin
                misalign_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port, one transaction in flight.
// Latency: gnt to rvalid minimum 2 cycles; misaligned data access responds 1 cycle after gnt.
// Backpressure: waits on mem_gnt_i/mem_rvalid_i; requesters hold until their gnt_o.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_arbiter_if.slave    bus,
    output logic            busy_o
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int CW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    state_e                state_q,  state_d;
    owner_e                owner_q,  owner_d;
    logic [CW-1:0]         starve_q, starve_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic                  we_q,     we_d;
    logic [BE_W-1:0]       be_q,     be_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;

    logic                  d_win, if_win, rsp_fire;
    logic [BE_W-1:0]       gen_be;
    logic [DATA_WIDTH-1:0] gen_wdata;
    logic                  gen_misalign;

    mem_be_gen #(.DATA_WIDTH(DATA_WIDTH)) u_be_gen (
        .size_i     (bus.d_size_i),
        .addr_lo_i  (bus.d_addr_i[1:0]),
        .wdata_i    (bus.d_wdata_i),
        .be_o       (gen_be),
        .wdata_o    (gen_wdata),
        .misalign_o (gen_misalign)
    );

    // Fetch only beats data once it has lost STARVE_LIMIT arbitrations in a row.
    always_comb begin
        d_win  = rst_n && (state_q == IDLE) && bus.d_req_i &&
                 !(bus.if_req_i && (starve_q == CW'(STARVE_LIMIT)));
        if_win = rst_n && (state_q == IDLE) && bus.if_req_i && !d_win;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (d_win) begin
                    owner_d = OWN_D;
                    addr_d  = {bus.d_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    we_d    = bus.d_we_i;
                    be_d    = gen_be;
                    wdata_d = gen_wdata;
                    state_d = gen_misalign ? ERR_RSP : WAIT_GNT;
                    if (bus.if_req_i && (starve_q != CW'(STARVE_LIMIT))) begin
                        starve_d = starve_q + CW'(1);
                    end
                end else if (if_win) begin
                    owner_d  = OWN_IF;
                    addr_d   = {bus.if_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    we_d     = 1'b0;
                    be_d     = '1;
                    wdata_d  = '0;
                    starve_d = '0;
                    state_d  = WAIT_GNT;
                end
            end
            WAIT_GNT: if (bus.mem_gnt_i)    state_d = WAIT_RSP;
            WAIT_RSP: if (bus.mem_rvalid_i) state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            starve_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end

    assign rsp_fire = (state_q == WAIT_RSP) && bus.mem_rvalid_i;

    assign bus.if_gnt_o    = if_win;
    assign bus.d_gnt_o     = d_win;

    assign bus.if_rvalid_o = rsp_fire && (owner_q == OWN_IF);
    assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;

    // Error responses carry zero data and never touch memory.
    assign bus.d_rvalid_o  = (rsp_fire && (owner_q == OWN_D)) || (state_q == ERR_RSP);
    assign bus.d_err_o     = (state_q == ERR_RSP);
    assign bus.d_rdata_o   = (rsp_fire && (owner_q == OWN_D)) ? bus.mem_rdata_i : '0;

    assign bus.mem_req_o   = (state_q == WAIT_GNT);
    assign bus.mem_we_o    = bus.mem_req_o && we_q;
    assign bus.mem_be_o    = bus.mem_req_o ? be_q    : '0;
    assign bus.mem_addr_o  = bus.mem_req_o ? addr_q  : '0;
    assign bus.mem_wdata_o = bus.mem_req_o ? wdata_q : '0;

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch read, data stores, misaligned loads,
// starvation release and reset abandoning an in-flight access.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst_n;
    logic busy;
    int   checks;
    int   errors;
    int   exp_starve;
    logic exp_if;

    mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_arbiter #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0;
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_size_i = 2'b00;
        bus.d_addr_i = 32'h0; bus.d_wdata_i = 32'h0;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;

        // Reset state, with a fetch request pending that must not be granted.
        #12;
        chk("rst_busy",     busy,            0);
        chk("rst_if_gnt",   bus.if_gnt_o,    0);
        chk("rst_mem_req",  bus.mem_req_o,   0);
        chk("rst_mem_be",   bus.mem_be_o,    0);
        chk("rst_d_rvalid", bus.d_rvalid_o,  0);
        chk("rst_starve",   dut.starve_q,    0);
        bus.if_req_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Fetch read of 0x104: gnt cycle 0, mem request cycle 1, rvalid cycle 2.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104;
        settle();
        chk("f_if_gnt", bus.if_gnt_o, 1);
        chk("f_d_gnt",  bus.d_gnt_o,  0);
        tick();
        bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
        settle();
        chk("f_mem_req",  bus.mem_req_o,  1);
        chk("f_mem_addr", bus.mem_addr_o, 32'h104);
        chk("f_mem_be",   bus.mem_be_o,   4'hF);
        chk("f_mem_we",   bus.mem_we_o,   0);
        chk("f_busy",     busy,           1);
        tick();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h00000013;
        settle();
        chk("f_if_rvalid", bus.if_rvalid_o, 1);
        chk("f_if_rdata",  bus.if_rdata_o,  32'h00000013);
        chk("f_d_rvalid",  bus.d_rvalid_o,  0);
        chk("f_mem_req_rsp", bus.mem_req_o, 0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        settle();
        chk("f_idle_busy",   busy,            0);
        chk("f_idle_rvalid", bus.if_rvalid_o, 0);

        // Byte store 0xAB to 0x203, memory grant delayed one cycle.
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_size_i = MEM_SIZE_B;
        bus.d_addr_i = 32'h203; bus.d_wdata_i = 32'h000000AB;
        settle();
        chk("sb_d_gnt",  bus.d_gnt_o,  1);
        chk("sb_if_gnt", bus.if_gnt_o, 0);
        tick();
        bus.d_req_i = 1'b0; bus.d_wdata_i = 32'h0;
        settle();
        chk("sb_mem_req_hold", bus.mem_req_o, 1);
        tick();
        bus.mem_gnt_i = 1'b1;
        settle();
        chk("sb_mem_addr",  bus.mem_addr_o,  32'h200);
        chk("sb_mem_be",    bus.mem_be_o,    4'h8);
        chk("sb_mem_wdata", bus.mem_wdata_o, 32'hABABABAB);
        chk("sb_mem_we",    bus.mem_we_o,    1);
        tick();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
        settle();
        chk("sb_d_rvalid",  bus.d_rvalid_o,  1);
        chk("sb_d_err",     bus.d_err_o,     0);
        chk("sb_d_rdata",   bus.d_rdata_o,   32'hDEADBEEF);
        chk("sb_if_rvalid", bus.if_rvalid_o, 0);
        tick();
        bus.mem_rvalid_i = 1'b0;

        // Half store 0x1234 to 0x202: upper half lanes.
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_size_i = MEM_SIZE_H;
        bus.d_addr_i = 32'h202; bus.d_wdata_i = 32'hFFFF1234;
        settle();
        chk("sh_d_gnt", bus.d_gnt_o, 1);
        tick();
        bus.d_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
        settle();
        chk("sh_mem_addr",  bus.mem_addr_o,  32'h200);
        chk("sh_mem_be",    bus.mem_be_o,    4'hC);
        chk("sh_mem_wdata", bus.mem_wdata_o, 32'h12341234);
        tick();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0;
        settle();
        chk("sh_d_rvalid", bus.d_rvalid_o, 1);
        tick();
        bus.mem_rvalid_i = 1'b0;

        // Misaligned word load at 0x102: error response next cycle, no memory request.
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_size_i = MEM_SIZE_W; bus.d_addr_i = 32'h102;
        settle();
        chk("mw_d_gnt", bus.d_gnt_o, 1);
        tick();
        bus.d_req_i = 1'b0;
        settle();
        chk("mw_mem_req",  bus.mem_req_o,  0);
        chk("mw_d_rvalid", bus.d_rvalid_o, 1);
        chk("mw_d_err",    bus.d_err_o,    1);
        chk("mw_d_rdata",  bus.d_rdata_o,  0);
        tick();
        chk("mw_after_rvalid", bus.d_rvalid_o, 0);
        chk("mw_after_err",    bus.d_err_o,    0);
        chk("mw_after_busy",   busy,           0);

        // Misaligned half load at 0x101.
        bus.d_req_i = 1'b1; bus.d_size_i = MEM_SIZE_H; bus.d_addr_i = 32'h101;
        settle();
        tick();
        bus.d_req_i = 1'b0;
        settle();
        chk("mh_d_err",   bus.d_err_o,   1);
        chk("mh_mem_req", bus.mem_req_o, 0);
        tick();

        // Both ports request in every IDLE cycle: data wins four times, then fetch.
        exp_starve = 0;
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_size_i = MEM_SIZE_W; bus.d_addr_i = 32'h400;
        for (int i = 0; i < 5; i++) begin
            settle();
            exp_if = (exp_starve == 4);
            chk("st_d_gnt",  bus.d_gnt_o,  !exp_if);
            chk("st_if_gnt", bus.if_gnt_o, exp_if);
            exp_starve = exp_if ? 0 : exp_starve + 1;
            tick();
            bus.mem_gnt_i = 1'b1;
            settle();
            chk("st_starve",     dut.starve_q,  exp_starve);
            chk("st_mem_addr",   bus.mem_addr_o, exp_if ? 32'h300 : 32'h400);
            chk("st_no_gnt_d",   bus.d_gnt_o,   0);
            chk("st_no_gnt_if",  bus.if_gnt_o,  0);
            tick();
            bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h500 + i;
            settle();
            chk("st_if_rvalid", bus.if_rvalid_o, exp_if);
            chk("st_d_rvalid",  bus.d_rvalid_o,  !exp_if);
            chk("st_rsp_gnt",   bus.d_gnt_o | bus.if_gnt_o, 0);
            tick();
            bus.mem_rvalid_i = 1'b0;
        end
        chk("st_final_starve", dut.starve_q, 0);
        bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
        settle();

        // Reset during WAIT_RSP abandons the read; the late response is ignored.
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_size_i = MEM_SIZE_W; bus.d_addr_i = 32'h100;
        settle();
        tick();
        bus.d_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        settle();
        chk("rr_busy_rsp", busy, 1);
        rst_n = 1'b0;
        settle();
        chk("rr_busy",    busy,          0);
        chk("rr_state",   dut.state_q,   IDLE);
        chk("rr_mem_req", bus.mem_req_o, 0);
        tick();
        rst_n = 1'b1;
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h55;
        settle();
        chk("rr_d_rvalid",  bus.d_rvalid_o,  0);
        chk("rr_if_rvalid", bus.if_rvalid_o, 0);
        chk("rr_d_rdata",   bus.d_rdata_o,   0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        settle();
        chk("rr_end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
